instr_decode_queue: RTL

Parametrised decode stage with a valid/ready handshake on both sides. It replaces the stall/flush-only decode register with a DEPTH-entry queue of already-decoded instructions. Each instruction is decoded as it is enqueued, using full RV32I(M) rules plus load/store size and illegal-instruction detection. It sits between IF and the dispatcher and absorbs dispatcher back-pressure without stalling fetch until the queue is full.

---
 rtl/instr_decode_queue_pkg.sv | 102 ++++++++++
 rtl/instr_decode_queue_decoder.sv | 135 +++++++++++++
 rtl/instr_decode_queue.sv | 78 +++++++
 3 files changed

// File: rtl/instr_decode_queue_pkg.sv
// Shared decode types for the decode queue: control bundle, decoded entry,
// opcode/funct constants and the ALU-op selection helper.
package instr_decode_queue_pkg;

    localparam int PC_W = 32;

    localparam logic [2:0] EXE_PIPE_ID_ALU     = 3'd0;
    localparam logic [2:0] EXE_PIPE_ID_LSU     = 3'd1;
    localparam logic [2:0] EXE_PIPE_ID_MUL     = 3'd2;
    localparam logic [2:0] EXE_PIPE_ID_DIV     = 3'd3;
    localparam logic [2:0] EXE_PIPE_ID_BR      = 3'd4;
    localparam logic [2:0] EXE_PIPE_ID_INVALID = 3'd7;

    typedef enum logic [2:0] {
        EXE_PIPE_ALU     = EXE_PIPE_ID_ALU,
        EXE_PIPE_LSU     = EXE_PIPE_ID_LSU,
        EXE_PIPE_MUL     = EXE_PIPE_ID_MUL,
        EXE_PIPE_DIV     = EXE_PIPE_ID_DIV,
        EXE_PIPE_BR      = EXE_PIPE_ID_BR,
        EXE_PIPE_INVALID = EXE_PIPE_ID_INVALID
    } exe_pipe_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {MUL_MUL, MUL_MULH, MUL_MULHSU, MUL_MULHU} mul_op_e;
    typedef enum logic [1:0] {DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU} div_op_e;

    typedef enum logic [2:0] {
        BR_BEQ = 3'b000, BR_BNE = 3'b001, BR_RSV2 = 3'b010, BR_RSV3 = 3'b011,
        BR_BLT = 3'b100, BR_BGE = 3'b101, BR_BLTU = 3'b110, BR_BGEU = 3'b111
    } branch_op_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SHAMT
    } imm_type_e;

    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} mem_size_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;
    localparam logic [2:0] STORE_F3_MAX = 3'b010;

    typedef struct packed {
        exe_pipe_e  exe_pipe;
        alu_op_e    alu_op;
        mul_op_e    mul_op;
        div_op_e    div_op;
        branch_op_e branch_op;
        imm_type_e  imm_type;
        logic       use_imm;
        logic       use_pc;
        logic       register_write;
        logic       mem_load;
        logic       mem_store;
        logic       branch;
        logic       jal;
        logic       jalr;
    } ctrl_t;

    typedef struct packed {
        ctrl_t            ctrl;
        logic [4:0]       a1;
        logic [4:0]       a2;
        logic [4:0]       rd;
        logic [31:0]      imm_ext;
        logic [PC_W-1:0]  pc;
        logic [PC_W-1:0]  pc_inc;
        mem_size_e        mem_size;
        logic             mem_unsigned;
        logic             illegal;
    } decoded_instr_t;

    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        unique case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_decode_queue_decoder.sv
// Combinational RV32I(M) decoder: raw instruction to decoded entry,
// pc fields left zero for the queue to fill in.
module instr_decoder
    import instr_decode_queue_pkg::*;
#(
    parameter bit SUPPORT_M = 1'b1
) (
    input  logic [31:0]    i_instr,
    output decoded_instr_t o_dec
);

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;

    assign w_op = i_instr[6:0];
    assign w_f3 = i_instr[14:12];
    assign w_f7 = i_instr[31:25];

    always_comb begin
        o_dec = '0;
        o_dec.ctrl.exe_pipe = EXE_PIPE_ALU;
        unique case (w_op)
            OP_R: begin
                o_dec.a1 = i_instr[19:15];
                o_dec.a2 = i_instr[24:20];
                o_dec.rd = i_instr[11:7];
                o_dec.ctrl.register_write = 1'b1;
                o_dec.ctrl.alu_op = alu_from_f3(w_f3, w_f7 == F7_ALT);
                if (w_f7 == F7_MULDIV) begin
                    o_dec.illegal = !SUPPORT_M;
                    o_dec.ctrl.exe_pipe = w_f3[2] ? EXE_PIPE_DIV : EXE_PIPE_MUL;
                    o_dec.ctrl.mul_op = mul_op_e'(w_f3[1:0]);
                    o_dec.ctrl.div_op = div_op_e'(w_f3[1:0]);
                end else if (w_f7 == F7_ALT) begin
                    o_dec.illegal = !(w_f3 == 3'b000 || w_f3 == 3'b101);
                end else if (w_f7 != F7_BASE) begin
                    o_dec.illegal = 1'b1;
                end
            end
            OP_IMM: begin
                o_dec.a1 = i_instr[19:15];
                o_dec.rd = i_instr[11:7];
                o_dec.ctrl.register_write = 1'b1;
                o_dec.ctrl.use_imm = 1'b1;
                o_dec.ctrl.alu_op =
                    alu_from_f3(w_f3, w_f3 == 3'b101 && i_instr[30]);
                o_dec.ctrl.imm_type = (w_f3[1:0] == 2'b01) ? IMM_SHAMT : IMM_I;
            end
            OP_LOAD: begin
                o_dec.a1 = i_instr[19:15];
                o_dec.rd = i_instr[11:7];
                o_dec.ctrl.exe_pipe = EXE_PIPE_LSU;
                o_dec.ctrl.register_write = 1'b1;
                o_dec.ctrl.mem_load = 1'b1;
                o_dec.ctrl.imm_type = IMM_I;
                o_dec.mem_size = mem_size_e'(w_f3[1:0]);
                o_dec.mem_unsigned = w_f3[2];
                o_dec.illegal = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
            end
            OP_STORE: begin
                o_dec.a1 = i_instr[19:15];
                o_dec.a2 = i_instr[24:20];
                o_dec.ctrl.exe_pipe = EXE_PIPE_LSU;
                o_dec.ctrl.mem_store = 1'b1;
                o_dec.ctrl.imm_type = IMM_S;
                o_dec.mem_size = mem_size_e'(w_f3[1:0]);
                o_dec.mem_unsigned = w_f3[2];
                o_dec.illegal = w_f3 > STORE_F3_MAX;
            end
            OP_BRANCH: begin
                o_dec.a1 = i_instr[19:15];
                o_dec.a2 = i_instr[24:20];
                o_dec.ctrl.exe_pipe = EXE_PIPE_BR;
                o_dec.ctrl.branch = 1'b1;
                o_dec.ctrl.branch_op = branch_op_e'(w_f3);
                o_dec.ctrl.imm_type = IMM_B;
                o_dec.illegal = (w_f3[2:1] == 2'b01);
            end
            OP_JAL: begin
                o_dec.rd = i_instr[11:7];
                o_dec.ctrl.exe_pipe = EXE_PIPE_BR;
                o_dec.ctrl.register_write = 1'b1;
                o_dec.ctrl.jal = 1'b1;
                o_dec.ctrl.imm_type = IMM_J;
            end
            OP_JALR: begin
                o_dec.a1 = i_instr[19:15];
                o_dec.rd = i_instr[11:7];
                o_dec.ctrl.exe_pipe = EXE_PIPE_BR;
                o_dec.ctrl.register_write = 1'b1;
                o_dec.ctrl.jalr = 1'b1;
                o_dec.ctrl.imm_type = IMM_I;
            end
            OP_LUI, OP_AUIPC: begin
                o_dec.rd = i_instr[11:7];
                o_dec.ctrl.register_write = 1'b1;
                o_dec.ctrl.use_imm = 1'b1;
                o_dec.ctrl.use_pc = (w_op == OP_AUIPC);
                o_dec.ctrl.imm_type = IMM_U;
            end
            default: begin
                // raw register fields are kept for trap reporting
                o_dec.a1 = i_instr[19:15];
                o_dec.a2 = i_instr[24:20];
                o_dec.rd = i_instr[11:7];
                o_dec.illegal = 1'b1;
            end
        endcase

        unique case (o_dec.ctrl.imm_type)
            IMM_I: o_dec.imm_ext = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S: o_dec.imm_ext = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: o_dec.imm_ext = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                    i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_J: o_dec.imm_ext = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                    i_instr[20], i_instr[30:21], 1'b0};
            IMM_U: o_dec.imm_ext = {i_instr[31:12], 12'b0};
            IMM_SHAMT: o_dec.imm_ext = {27'b0, i_instr[24:20]};
            default: o_dec.imm_ext = '0;
        endcase

        if (o_dec.rd == 5'd0) o_dec.ctrl.register_write = 1'b0;
        if (o_dec.illegal) begin
            o_dec.ctrl.register_write = 1'b0;
            o_dec.ctrl.mem_load = 1'b0;
            o_dec.ctrl.mem_store = 1'b0;
            o_dec.ctrl.branch = 1'b0;
            o_dec.ctrl.jal = 1'b0;
            o_dec.ctrl.jalr = 1'b0;
            o_dec.ctrl.exe_pipe = EXE_PIPE_INVALID;
        end
    end

endmodule

// File: rtl/instr_decode_queue.sv
// Decode stage: instructions are decoded on enqueue into a small FIFO
// that absorbs dispatcher back-pressure.
module instr_decode_queue
    import instr_decode_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int XLEN        = PC_W,
    parameter bit SUPPORT_M   = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [31:0]                      in_instr,
    input  logic [XLEN-1:0]                  in_pc,
    input  logic [XLEN-1:0]                  in_pc_inc,
    output logic                             out_valid,
    input  logic                             out_ready,
    output decoded_instr_t                   out_entry,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    decoded_instr_t r_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    decoded_instr_t w_dec;
    decoded_instr_t w_wr;
    logic           w_push;
    logic           w_pop;

    instr_decoder #(.SUPPORT_M(SUPPORT_M)) u_dec (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    always_comb begin
        w_wr = w_dec;
        w_wr.pc = PC_W'(in_pc);
        w_wr.pc_inc = PC_W'(in_pc_inc);
    end

    assign in_ready  = (r_count < CNT_W'(QUEUE_DEPTH)) && !rst;
    assign out_valid = (r_count != '0);
    assign occupancy = r_count;
    assign out_entry = r_mem[r_head];

    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // storage is never reset; out_entry only matters while out_valid
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= w_wr;
    end

endmodule
